// File: rtl/stream_pkg.sv
// Shared defaults and the feeder state encoding for the stream feeder slice.
package stream_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAIR = 2'd1,
        TAIL = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Circular word FIFO that can pop one or two words per cycle and exposes
// both the head word and the word behind it.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop1,
    input  logic             pop2,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] head_next,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_next_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pop_n;
    logic             do_push;

    // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
    always_comb begin
        do_push     = push && (count_q < CNT_W'(DEPTH));
        pop_n       = '0;
        if (pop2 && (count_q >= CNT_W'(2))) begin
            pop_n = CNT_W'(2);
        end else if (pop1 && (count_q >= CNT_W'(1))) begin
            pop_n = CNT_W'(1);
        end
        rd_next_ptr = rd_ptr_q + PTR_W'(1);
        wr_ptr_d    = do_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_n);
        count_d     = count_q + CNT_W'(do_push) - pop_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign head_next = mem_q[rd_next_ptr];
    assign count     = count_q;

endmodule

// File: rtl/stream_feeder.sv
// Pairs consecutive input words into a registered two-stream output stage.
// Define STREAM_FEEDER_CHECKSUM_EN to add the pair_sum running checksum port.
module stream_feeder
    import stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] first_stream,
`ifdef STREAM_FEEDER_CHECKSUM_EN
    output logic [WIDTH-1:0] second_stream,
    output logic [WIDTH-1:0] pair_sum
`else
    output logic [WIDTH-1:0] second_stream
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] head, head_next;
    logic             load_pair, load_tail, stage_free, accept;

    feeder_state_e    state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] first_q, first_d;
    logic [WIDTH-1:0] second_q, second_d;
    logic             flush_pending_q, flush_pending_d;

    assign in_ready = count < CNT_W'(DEPTH);

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop1      (load_tail),
        .pop2      (load_pair),
        .head      (head),
        .head_next (head_next),
        .count     (count)
    );

    // A full pair always takes priority; the tail only goes out with a lone word.
    always_comb begin
        stage_free      = !out_valid_q || out_ready;
        accept          = out_valid_q && out_ready;
        load_pair       = stage_free && (count >= CNT_W'(2));
        load_tail       = stage_free && flush_pending_q && (count == CNT_W'(1));
        state_d         = state_q;
        first_d         = first_q;
        second_d        = second_q;
        flush_pending_d = flush_pending_q;
        if (load_pair) begin
            state_d  = PAIR;
            first_d  = head;
            second_d = head_next;
        end else if (load_tail) begin
            state_d  = TAIL;
            first_d  = head;
            second_d = '0;
        end else if (accept) begin
            state_d = IDLE;
        end
        if (load_tail || (stage_free && (count == '0))) begin
            flush_pending_d = 1'b0;
        end
        if (flush) begin
            flush_pending_d = 1'b1;
        end
        out_valid_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            out_valid_q     <= 1'b0;
            first_q         <= '0;
            second_q        <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            first_q         <= first_d;
            second_q        <= second_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign first_stream  = first_q;
    assign second_stream = second_q;

`ifdef STREAM_FEEDER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = sum_q + first_q + second_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign pair_sum = sum_q;
`endif

endmodule

// File: tb/tb_stream_feeder.sv
// Randomized and directed bench for stream_feeder against a queue-based
// reference model; honours STREAM_FEEDER_CHECKSUM_EN when defined.
module tb_stream_feeder;
    import stream_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] first_stream;
    logic [WIDTH-1:0] second_stream;
`ifdef STREAM_FEEDER_CHECKSUM_EN
    logic [WIDTH-1:0] pair_sum;
`endif

    always #5 clk = ~clk;

    stream_feeder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .first_stream  (first_stream),
`ifdef STREAM_FEEDER_CHECKSUM_EN
        .second_stream (second_stream),
        .pair_sum      (pair_sum)
`else
        .second_stream (second_stream)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the words waiting, the pair on display, and the flush request.
    logic [WIDTH-1:0] mq [$];
    bit               m_valid;
    bit               m_pending;
    logic [WIDTH-1:0] m_first, m_second, m_sum;
    logic [63:0]      got [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkCycle();
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        if (m_valid) begin
            checkOutput("first_stream", first_stream, m_first);
            checkOutput("second_stream", second_stream, m_second);
        end
`ifdef STREAM_FEEDER_CHECKSUM_EN
        checkOutput("pair_sum", pair_sum, m_sum);
`endif
    endtask

    task automatic modelReset();
        mq.delete();
        m_valid   = 1'b0;
        m_pending = 1'b0;
        m_first   = '0;
        m_second  = '0;
        m_sum     = '0;
    endtask

    task automatic modelStep(input bit iv, input logic [WIDTH-1:0] id, input bit fl, input bit ordy);
        int cnt;
        bit stage_free;
        cnt        = mq.size();
        stage_free = !m_valid || ordy;
        if (m_valid && ordy) m_sum = m_sum + m_first + m_second;
        if (stage_free && cnt >= 2) begin
            m_first  = mq.pop_front();
            m_second = mq.pop_front();
            m_valid  = 1'b1;
        end else if (stage_free && m_pending && cnt == 1) begin
            m_first   = mq.pop_front();
            m_second  = '0;
            m_valid   = 1'b1;
            m_pending = 1'b0;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        if (stage_free && cnt == 0) m_pending = 1'b0;
        if (iv && cnt < DEPTH) mq.push_back(id);
        if (fl) m_pending = 1'b1;
    endtask

    // Called at a falling edge; drives one cycle and checks after the next rise.
    task automatic applyStimulus(input bit iv, input logic [WIDTH-1:0] id, input bit fl, input bit ordy);
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
        #1;
        if (out_valid && ordy) got.push_back({first_stream, second_stream});
        modelStep(iv, id, fl, ordy);
        @(posedge clk);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic applyReset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic checkPair(input string tag, input int idx, input logic [31:0] f, input logic [31:0] s);
        if (idx < got.size()) begin
            checkOutput({tag, "_first"}, got[idx][63:32], f);
            checkOutput({tag, "_second"}, got[idx][31:0], s);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        applyReset(2);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_first", first_stream, 32'd0);
        checkOutput("reset_second", second_stream, 32'd0);
`ifdef STREAM_FEEDER_CHECKSUM_EN
        checkOutput("reset_pair_sum", pair_sum, 32'd0);
`endif

        // Basic pairing of 1,2,3,4,5,9.
        got.delete();
        applyStimulus(1, 32'd1, 0, 1);
        applyStimulus(1, 32'd2, 0, 1);
        applyStimulus(1, 32'd3, 0, 1);
        applyStimulus(1, 32'd4, 0, 1);
        applyStimulus(1, 32'd5, 0, 1);
        applyStimulus(1, 32'd9, 0, 1);
        repeat (4) applyStimulus(0, '0, 0, 1);
        checkOutput("basic_pair_count", 32'(got.size()), 32'd3);
        checkPair("basic0", 0, 32'd1, 32'd2);
        checkPair("basic1", 1, 32'd3, 32'd4);
        checkPair("basic2", 2, 32'd5, 32'd9);
`ifdef STREAM_FEEDER_CHECKSUM_EN
        checkOutput("basic_sum", pair_sum, 32'd24);
`endif

        // Backpressure: fill output stage and FIFO, one extra word must bounce.
        got.delete();
        for (int i = 0; i < DEPTH + 3; i++) applyStimulus(1, 32'(100 + i), 0, 0);
        checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
        checkOutput("bp_held_first", first_stream, 32'd100);
        repeat (8) applyStimulus(0, '0, 0, 1);
        checkOutput("bp_pair_count", 32'(got.size()), 32'(DEPTH / 2 + 1));
        for (int i = 0; i < DEPTH / 2 + 1; i++) checkPair("bp", i, 32'(100 + 2 * i), 32'(101 + 2 * i));

        // Flush of a lone word produces a tail pair.
        got.delete();
        applyStimulus(1, 32'd7, 0, 1);
        applyStimulus(0, '0, 1, 1);
        applyStimulus(0, '0, 0, 0);
        checkOutput("tail_state", 32'(dut.state_q), 32'(TAIL));
        repeat (3) applyStimulus(0, '0, 0, 1);
        checkOutput("tail_pair_count", 32'(got.size()), 32'd1);
        checkPair("tail", 0, 32'd7, 32'd0);

        // Flush with nothing queued emits nothing.
        got.delete();
        applyStimulus(0, '0, 1, 1);
        repeat (3) applyStimulus(0, '0, 0, 1);
        checkOutput("empty_flush_pairs", 32'(got.size()), 32'd0);

        // Reach DEPTH-1 queued, then push and pop together across the wrap.
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 32'(200 + i), 0, 0);
        checkOutput("wrap_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 32'(300 + i), 0, 1);
        repeat (12) applyStimulus(0, '0, 1, 1);

        // Reset while a pair is held with three words queued.
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'(51 + i), 0, 0);
        applyReset(1);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        got.delete();
        applyStimulus(1, 32'd10, 0, 1);
        applyStimulus(1, 32'd20, 0, 1);
        repeat (3) applyStimulus(0, '0, 0, 1);
        checkOutput("midreset_pair_count", 32'(got.size()), 32'd1);
        checkPair("midreset", 0, 32'd10, 32'd20);

        // Random traffic with occasional flushes and stalls.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom(),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (DEPTH + 4) applyStimulus(0, '0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stream_feeder.md
STREAM_FEEDER -- requirements
Module: stream_feeder

Interface
REQ-001 Parameter WIDTH, default 32, data width of input words and of each output stream.
REQ-002 Parameter DEPTH, default 8, FIFO capacity in words; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  producer offers in_data.
REQ-006 in_ready  output  1  feeder can accept a word this cycle.
REQ-007 in_data  input  WIDTH  word to enqueue.
REQ-008 flush  input  1  one-cycle pulse; emit any unpaired tail word.
REQ-009 out_valid  output  1  first_stream/second_stream hold a valid pair.
REQ-010 out_ready  input  1  consumer (stream summer) accepts the pair.
REQ-011 first_stream  output  WIDTH  older word of the pair.
REQ-012 second_stream  output  WIDTH  newer word of the pair, or 0 on flush tail.
REQ-013 pair_sum  output  WIDTH  checksum (present only per REQ-030).

Function
REQ-014 Input handshake SHALL complete when in_valid && in_ready; the word is written to the FIFO tail at that edge.
REQ-015 in_ready SHALL equal (count < DEPTH), count being the registered FIFO occupancy; a same-cycle pop does not raise in_ready.
REQ-016 Output pair SHALL be held in a registered output stage; out_valid, first_stream and second_stream SHALL not change while out_valid && !out_ready.
REQ-017 Output stage SHALL load when (!out_valid || out_ready) and count >= 2: first = FIFO head, second = head+1, both popped.
REQ-018 Latency: second word of a pair accepted at edge k into an empty feeder with free output stage -> out_valid high after edge k+1.
REQ-019 Push and pop in the same cycle SHALL both occur; count updates by +1-2 accordingly.
REQ-020 FSM states: IDLE (output empty), PAIR (out_valid, normal pair), TAIL (out_valid, flush tail); transitions on load/accept only.
REQ-021 flush SHALL set flush_pending; when flush_pending, count == 1 and output stage free, load first = head, second = 0, pop one, enter TAIL, clear flush_pending.
REQ-022 flush_pending SHALL clear without emission if count == 0 when the output stage is free; count >= 2 loads pairs first, pending kept.
REQ-023 Words arriving after flush but before the tail loads SHALL be paired normally; tail emitted only if count is still 1.
REQ-024 Pointers SHALL wrap modulo DEPTH; count width $clog2(DEPTH+1).
REQ-025 Push while full SHALL be ignored (in_ready low); out_ready while !out_valid SHALL have no effect.

Reset
REQ-026 On rst_n low at a clock edge: count, pointers, flush_pending = 0; state IDLE; out_valid = 0; first_stream = second_stream = 0; pair_sum = 0; in_ready = 1 after the edge.
REQ-027 Reset mid-operation SHALL discard FIFO contents and any held pair without emission.

Configuration
REQ-028 Macro STREAM_FEEDER_CHECKSUM_EN selects the checksum feature.
REQ-029 Without it, pair_sum port and its register SHALL not exist.
REQ-030 With it, pair_sum SHALL accumulate first_stream + second_stream (mod 2^WIDTH) at every edge where out_valid && out_ready, matching the consumer's expected running sum.

Structure
REQ-031 Package stream_pkg SHALL hold WIDTH/DEPTH defaults and the feeder state enum (IDLE, PAIR, TAIL).
REQ-032 FIFO storage SHALL be sub-module stream_fifo (push, pop1, pop2, head, head+1, count); the top holds FSM and output stage.

Verification
REQ-033 Reset: hold rst_n low 2 cycles -> out_valid 0, in_ready 1, streams 0, pair_sum 0.
REQ-034 Push 1,2,3,4,5,9, out_ready=1 -> pairs (1,2),(3,4),(5,9) in order; pair_sum = 24 (CHECKSUM_EN).
REQ-035 Backpressure: out_ready=0, push DEPTH+2 words -> first pair held stable, in_ready low once FIFO full, no word lost after release.
REQ-036 Push 7 then flush pulse -> pair (7,0) emitted, state TAIL; flush with empty FIFO -> no output.
REQ-037 Simultaneous push and pop at count==DEPTH-1 -> count correct, ordering preserved across pointer wrap.
REQ-038 Assert rst_n low while out_valid with 3 words queued -> all discarded; subsequent 10,20 -> pair (10,20).
